computer_system_pio_in: RTL and testbench

Avalon-MM slave input port for the HPS lightweight bus: the read-side counterpart of the output PIO that drives Mandelbrot control words to the FPGA. It synchronizes a DATA_WIDTH-bit status vector from the compute fabric (done flags, busy bits, iteration-complete strobes), latches selected edges into a sticky capture register, and raises a level interrupt to the HPS on masked captures. Registers are read and written by the ARM over the same 2-bit word-addressed slave interface used by the output PIOs.

---
 rtl/computer_system_pio_in_if.sv | 42 ++++
 rtl/computer_system_pio_in.sv | 237 +++++++++++++++++++++++
 tb/tb_computer_system_pio_in.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/computer_system_pio_in_if.sv
// -----------------------------------------------------------------------------
// computer_system_pio_in_if
//
// Purpose:
//   Avalon-MM slave bus bundle for the HPS lightweight-bus input PIO.
//   The lines are the 2-bit word-addressed register bus that the output PIOs
//   also use.
//
// Signals:
//   address    [1:0]  word address (0 data, 1 irq mask, 2 reserved, 3 capture)
//   chipselect        slave select (qualifies writes only)
//   write_n           active-low write strobe
//   writedata  [31:0] write data
//   readdata   [31:0] read data, zero latency, zero-extended
//
// Modports:
//   master - bus initiator (HPS bridge / testbench)
//   slave  - the PIO register block
// -----------------------------------------------------------------------------
interface computer_system_pio_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface : computer_system_pio_in_if

// File: rtl/computer_system_pio_in.sv
// -----------------------------------------------------------------------------
// computer_system_pio_in
//
// Purpose:
//   Avalon-MM input PIO for the HPS lightweight bus. A DATA_WIDTH-bit status
//   vector from the compute fabric is synchronized into the clk domain,
//   selected edges are latched into a sticky write-1-to-clear capture
//   register, and a level interrupt is raised on masked captures.
//
// Optional feature macro:
//   PIO_IN_IRQ_MASK_EN - when defined, the irq mask register (address 1) and
//   the irq output logic are built. When undefined, address 1 reads 0, writes
//   to it are ignored and irq is tied low; capture and warm-up logic remain.
//
// Parameters:
//   DATA_WIDTH  (1..32) width of in_port and of every data register
//   SYNC_STAGES (2..4)  synchronizer depth
//   EDGE_TYPE   0 rising, 1 falling, 2 any edge
//
// Ports:
//   clk      in   single system clock
//   reset_n  in   asynchronous active-low reset
//   bus      slave Avalon-MM register bus (address/chipselect/write_n/
//                  writedata/readdata)
//   in_port  in   asynchronous status inputs
//   irq      out  level interrupt, active high
//
// Register map (word addresses):
//   0 data (synchronized in_port, read only)
//   1 irq mask (read/write)
//   2 reserved (reads 0)
//   3 edge capture (read, write-1-to-clear)
// -----------------------------------------------------------------------------
module computer_system_pio_in #(
  parameter int DATA_WIDTH  = 27,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  computer_system_pio_in_if.slave       bus,
  input  logic [DATA_WIDTH-1:0]         in_port,
  output logic                          irq
);

  // Counter only needs to reach SYNC_STAGES (max 4).
  localparam int CNT_W = 3;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q;
  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_d;
  logic [DATA_WIDTH-1:0]                  sync_s;
  logic [DATA_WIDTH-1:0]                  prev_q;

  logic [CNT_W-1:0]                       cnt_q;
  logic [CNT_W-1:0]                       cnt_d;
  logic                                   armed_q;
  logic                                   armed_d;

  logic [DATA_WIDTH-1:0]                  edge_raw_s;
  logic [DATA_WIDTH-1:0]                  edge_s;

  logic                                   wr_en_s;
  logic [DATA_WIDTH-1:0]                  wdata_s;
  logic [DATA_WIDTH-1:0]                  clr_s;
  logic [DATA_WIDTH-1:0]                  cap_q;
  logic [DATA_WIDTH-1:0]                  cap_d;

  logic [DATA_WIDTH-1:0]                  mask_rd_s;
  logic [31:0]                            rd_s;

  // Bits of writedata above DATA_WIDTH carry no meaning for this block.
  logic [31:0]                            unused_wdata_s;

  assign unused_wdata_s = bus.writedata;
  assign wdata_s        = bus.writedata[DATA_WIDTH-1:0];
  assign wr_en_s        = bus.chipselect & ~bus.write_n;
  assign sync_s         = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Synchronizer chain: stage 0 samples the pins, the last stage is "sync".
  // ---------------------------------------------------------------------------
  // Next-state of the synchronizer shift chain.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = in_port;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Synchronizer flops and the one-clock-delayed copy used for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Warm-up: edges are ignored until the synchronizer and prev hold real
  // samples, so inputs already high at reset release never look like edges.
  // armed rises at the (SYNC_STAGES+1)th clock after release and then sticks.
  // ---------------------------------------------------------------------------
  // Warm-up counter next-state.
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (armed_q) begin
      cnt_d   = cnt_q;
      armed_d = 1'b1;
    end else if (cnt_q == CNT_W'(SYNC_STAGES)) begin
      armed_d = 1'b1;
    end else begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Warm-up counter and armed flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Edge detection
  // ---------------------------------------------------------------------------
  // Polarity selection; unknown EDGE_TYPE values fall back to rising.
  always_comb begin
    edge_raw_s = '0;
    case (EDGE_TYPE)
      32'sd0:  edge_raw_s =  sync_s & ~prev_q;
      32'sd1:  edge_raw_s = ~sync_s &  prev_q;
      32'sd2:  edge_raw_s =  sync_s ^  prev_q;
      default: edge_raw_s =  sync_s & ~prev_q;
    endcase
  end

  // Gate edges until warm-up has completed.
  always_comb begin
    edge_s = '0;
    if (armed_q) begin
      edge_s = edge_raw_s;
    end else begin
      edge_s = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Edge capture register (sticky, write-1-to-clear)
  // ---------------------------------------------------------------------------
  // Clear vector from a write to address 3.
  always_comb begin
    clr_s = '0;
    if (wr_en_s && (bus.address == 2'd3)) begin
      clr_s = wdata_s;
    end else begin
      clr_s = '0;
    end
  end

  // The set term is OR-ed after the clear so a coincident edge is never lost.
  always_comb begin
    cap_d = (cap_q & ~clr_s) | edge_s;
  end

  // Edge capture register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_q <= '0;
    end else begin
      cap_q <= cap_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt mask and irq
  // ---------------------------------------------------------------------------
`ifdef PIO_IN_IRQ_MASK_EN
  logic [DATA_WIDTH-1:0] mask_q;
  logic [DATA_WIDTH-1:0] mask_d;

  // Mask register next-state from writes to address 1.
  always_comb begin
    mask_d = mask_q;
    if (wr_en_s && (bus.address == 2'd1)) begin
      mask_d = wdata_s;
    end else begin
      mask_d = mask_q;
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign mask_rd_s = mask_q;
  // Decoded straight from registers so irq tracks capture/mask with no lag.
  assign irq       = |(cap_q & mask_q);
`else
  assign mask_rd_s = '0;
  assign irq       = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read path: zero-latency mux on address; chipselect does not gate reads.
  // ---------------------------------------------------------------------------
  // Readdata multiplexer with zero extension above DATA_WIDTH.
  always_comb begin
    rd_s = '0;
    case (bus.address)
      2'd0:    rd_s[DATA_WIDTH-1:0] = sync_s;
      2'd1:    rd_s[DATA_WIDTH-1:0] = mask_rd_s;
      2'd2:    rd_s = '0;
      2'd3:    rd_s[DATA_WIDTH-1:0] = cap_q;
      default: rd_s = '0;
    endcase
  end

  assign bus.readdata = rd_s;

endmodule : computer_system_pio_in

// File: tb/tb_computer_system_pio_in.sv
// -----------------------------------------------------------------------------
// tb_computer_system_pio_in
//
// Three instances share one bus and one in_port:
//   u0: EDGE_TYPE 0, SYNC_STAGES 2
//   u1: EDGE_TYPE 1, SYNC_STAGES 3
//   u2: EDGE_TYPE 2, SYNC_STAGES 2
// A reference model keeps the history of sampled in_port values and derives
// sync/prev as delayed samples; stimulus pushes expected reads into a queue,
// and a monitor pops/compares reads and checks irq every cycle.
// -----------------------------------------------------------------------------
module tb_computer_system_pio_in;

  localparam int DW = 27;
  localparam int N  = 3;
`ifdef PIO_IN_IRQ_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  int s_of  [N] = '{2, 3, 2};
  int et_of [N] = '{0, 1, 2};

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    address;
  logic          cs;
  logic          wn;
  logic [31:0]   wd;
  logic [DW-1:0] in_port;
  logic          rd_pend;

  logic [31:0]   rd_a  [N];
  logic          irq_a [N];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  computer_system_pio_in_if if0 ();
  computer_system_pio_in_if if1 ();
  computer_system_pio_in_if if2 ();

  assign if0.address = address; assign if0.chipselect = cs;
  assign if0.write_n = wn;      assign if0.writedata  = wd;
  assign if1.address = address; assign if1.chipselect = cs;
  assign if1.write_n = wn;      assign if1.writedata  = wd;
  assign if2.address = address; assign if2.chipselect = cs;
  assign if2.write_n = wn;      assign if2.writedata  = wd;
  assign rd_a[0] = if0.readdata;
  assign rd_a[1] = if1.readdata;
  assign rd_a[2] = if2.readdata;

  computer_system_pio_in #(.DATA_WIDTH(DW), .SYNC_STAGES(2), .EDGE_TYPE(0)) u0 (
    .clk(clk), .reset_n(reset_n), .bus(if0), .in_port(in_port), .irq(irq_a[0]));
  computer_system_pio_in #(.DATA_WIDTH(DW), .SYNC_STAGES(3), .EDGE_TYPE(1)) u1 (
    .clk(clk), .reset_n(reset_n), .bus(if1), .in_port(in_port), .irq(irq_a[1]));
  computer_system_pio_in #(.DATA_WIDTH(DW), .SYNC_STAGES(2), .EDGE_TYPE(2)) u2 (
    .clk(clk), .reset_n(reset_n), .bus(if2), .in_port(in_port), .irq(irq_a[2]));

  // ---------------- reference model ----------------
  int            e;          // clock edges since reset release
  logic [DW-1:0] hist [$];   // hist[j-1] = in_port sampled at edge j
  logic [DW-1:0] cap_m [N];
  logic [DW-1:0] mask_m;

  function automatic logic [DW-1:0] h(int j);
    if (j < 1 || j > hist.size()) return '0;
    return hist[j-1];
  endfunction

  function automatic logic [DW-1:0] edge_vec(int t, logic [DW-1:0] s, logic [DW-1:0] p);
    if (t == 0) return s & ~p;
    if (t == 1) return ~s & p;
    return s ^ p;
  endfunction

  function automatic logic [31:0] mread(int i, logic [1:0] a);
    logic [31:0] r;
    r = '0;
    if (a == 2'd0) r[DW-1:0] = h(e - s_of[i] + 1);
    if (a == 2'd1 && MASK_EN) r[DW-1:0] = mask_m;
    if (a == 2'd3) r[DW-1:0] = cap_m[i];
    return r;
  endfunction

  function automatic logic mirq(int i);
    return MASK_EN && ((cap_m[i] & mask_m) != '0);
  endfunction

  initial begin
    logic [DW-1:0] clr;
    logic [DW-1:0] ev;
    e = 0;
    mask_m = '0;
    for (int i = 0; i < N; i++) cap_m[i] = '0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        e = 0;
        hist.delete();
        mask_m = '0;
        for (int i = 0; i < N; i++) cap_m[i] = '0;
      end else begin
        clr = '0;
        if (cs && !wn && address == 2'd3) clr = wd[DW-1:0];
        if (cs && !wn && address == 2'd1 && MASK_EN) mask_m = wd[DW-1:0];
        e = e + 1;
        hist.push_back(in_port);
        for (int i = 0; i < N; i++) begin
          // sync/prev seen before this edge are the samples S and S+1 edges back
          ev = '0;
          if (e >= s_of[i] + 2) ev = edge_vec(et_of[i], h(e - s_of[i]), h(e - s_of[i] - 1));
          cap_m[i] = (cap_m[i] & ~clr) | ev;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [N-1:0][31:0] ex;
    logic [1:0]         a;
  } rd_t;
  rd_t sb [$];

  initial begin
    rd_t t;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        n_cmp++;
        if (irq_a[i] !== mirq(i)) begin
          n_err++;
          $display("FAIL irq u%0d t=%0t: got %b expected %b", i, $time, irq_a[i], mirq(i));
        end
      end
      if (rd_pend) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL sb_underflow t=%0t: got empty queue expected an entry", $time);
        end else begin
          t = sb.pop_front();
          for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (rd_a[i] !== t.ex[i]) begin
              n_err++;
              $display("FAIL read u%0d addr%0d t=%0t: got %h expected %h",
                       i, t.a, $time, rd_a[i], t.ex[i]);
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op_idle();
    tick();
    cs = 1'b0; wn = 1'b1; rd_pend = 1'b0;
  endtask

  task automatic op_wr(input logic [1:0] a, input logic [31:0] d);
    tick();
    cs = 1'b1; wn = 1'b0; address = a; wd = d; rd_pend = 1'b0;
  endtask

  task automatic op_rd(input logic [1:0] a, input logic sel);
    rd_t t;
    tick();
    cs = sel; wn = 1'b1; address = a; rd_pend = 1'b1;
    t.a = a;
    for (int i = 0; i < N; i++) t.ex[i] = mread(i, a);
    sb.push_back(t);
  endtask

  task automatic release_reset();
    tick();
    reset_n = 1'b1; cs = 1'b0; wn = 1'b1; rd_pend = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; address = 2'd0; cs = 1'b0; wn = 1'b1; wd = 32'd0;
    in_port = '1; rd_pend = 1'b0;

    // Reset values with inputs held high.
    for (int a = 0; a < 4; a++) op_rd(2'(a), 1'b1);
    release_reset();
    // Inputs high at release: data fills in, capture stays clear.
    for (int k = 0; k < 24; k++) op_rd((k % 2 == 0) ? 2'd0 : 2'd3, 1'b1);

    // Mask width, ignored addresses, reserved read.
    op_wr(2'd1, 32'hFFFF_FFFF);
    op_rd(2'd1, 1'b1);
    op_wr(2'd0, 32'h1234_5678);
    op_wr(2'd2, 32'hDEAD_BEEF);
    for (int a = 0; a < 4; a++) op_rd(2'(a), 1'b1);

    // Rising bit0 with mask 0x1.
    op_wr(2'd1, 32'h0);
    op_idle(); in_port = '0;
    repeat (6) op_idle();
    op_wr(2'd3, 32'hFFFF_FFFF);
    op_wr(2'd1, 32'h1);
    op_idle(); in_port[0] = 1'b1;
    repeat (6) op_rd(2'd3, 1'b1);
    op_wr(2'd3, 32'h1);
    repeat (2) op_rd(2'd3, 1'b1);

    // Bit4 edge against a coincident clear at several alignments.
    for (int off = 0; off < 4; off++) begin
      op_idle(); in_port[4] = 1'b0;
      repeat (5) op_idle();
      op_wr(2'd3, 32'hFFFF_FFFF);
      op_idle(); in_port[4] = 1'b1;
      repeat (off) op_idle();
      op_wr(2'd3, 32'h10);
      repeat (2) op_rd(2'd3, 1'b1);
    end

    // Double toggle on bit26, then unmask it.
    op_wr(2'd1, 32'h0);
    repeat (5) op_idle();
    op_wr(2'd3, 32'hFFFF_FFFF);
    op_idle(); in_port[26] = ~in_port[26];
    repeat (3) op_idle();
    op_idle(); in_port[26] = ~in_port[26];
    repeat (5) op_rd(2'd3, 1'b1);
    op_wr(2'd1, 32'h0400_0000);
    repeat (2) op_rd(2'd1, 1'b1);

    // Randomized traffic with occasional mid-run resets.
    for (int it = 0; it < 1500; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r <= 3)      op_rd(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
      else if (r <= 5) op_wr(2'($urandom_range(0, 3)), $urandom());
      else if (r == 6) op_wr(2'd3, $urandom() & $urandom());
      else if (r == 7) op_wr(2'd1, $urandom());
      else             op_idle();
      if ($urandom_range(0, 2) == 0)
        in_port = in_port ^ (DW'($urandom()) & DW'($urandom()) & DW'($urandom()));
      if (it % 400 == 399) begin
        tick();
        reset_n = 1'b0; cs = 1'b0; wn = 1'b1; rd_pend = 1'b0;
        op_rd(2'd3, 1'b1);
        op_rd(2'd0, 1'b1);
        release_reset();
      end
    end

    repeat (3) op_idle();
    repeat (2) @(posedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_computer_system_pio_in
